rx_arp: RTL and testbench
=========================

RX_ARP -- requirements
Module: rx_arp

Interface
REQ-001 Parameter CHECK_IP, default 1: when 1, frames whose target IP differs from local_ip are rejected.
REQ-002 Parameter MAX_PAD, default 8'd64: maximum count of trailing bytes after byte 27 before the frame is declared bad.
REQ-003 s_axis_aclk  in  1  single clock; all logic rising-edge.
REQ-004 s_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  in  8  ARP payload byte; Ethernet header already stripped.
REQ-006 s_axis_tvalid  in  1  byte valid.
REQ-007 s_axis_tready  out  1  ready; 1 in every state after reset.
REQ-008 s_axis_tuser  in  1  first byte of frame marker.
REQ-009 s_axis_tlast  in  1  last byte of frame.
REQ-010 local_ip  in  32  own IP, compared to target IP.
REQ-011 arp_opcode  out  16  received opcode.
REQ-012 arp_srcMac  out  48  sender MAC.
REQ-013 arp_srcIP  out  32  sender IP.
REQ-014 arp_destMac  out  48  target MAC.
REQ-015 arp_destIP  out  32  target IP.
REQ-016 arp_valid  out  1  one-cycle pulse: fields hold a new good frame.
REQ-017 arp_error  out  1  one-cycle pulse: frame discarded.

Function
REQ-018 A beat is accepted when s_axis_tvalid & s_axis_tready; nothing advances on any other cycle.
REQ-019 States: IDLE, HEADER, PAD, CHECK.
REQ-020 IDLE: an accepted beat with tuser=1 is stored as byte 0, the byte counter is set to 1, and the next state is HEADER; accepted beats with tuser=0 are ignored.
REQ-021 HEADER: accepted byte n (1..27) is stored at big-endian offset n using the wire order HwType[2], Proto[2], HwLen, ProtoLen, opcode[2], srcMac[6], srcIP[4], destMac[6], destIP[4]; the counter increments per beat.
REQ-022 HEADER, tlast on byte n<27: arp_error pulses and the next state is IDLE.
REQ-023 HEADER, byte 27 accepted: with tlast=1 the next state is CHECK; with tlast=0 the next state is PAD and the pad counter clears.
REQ-024 PAD: accepted bytes are discarded; tlast leads to CHECK; if the pad count reaches MAX_PAD without tlast, arp_error pulses and the next state is IDLE.
REQ-025 Accepted beat with tuser=1 in HEADER or PAD: arp_error pulses for the aborted frame, and the beat is restarted as byte 0 of a new frame in the same cycle.
REQ-026 CHECK (one cycle): the frame is good iff HwType=16'h0001, Proto=16'h0800, HwLen=8'd6, ProtoLen=8'd4, opcode is 1 or 2, and (CHECK_IP=0 or destIP=local_ip).
REQ-027 Good frame: all arp_* field outputs load from the capture registers and arp_valid pulses; bad frame: arp_error pulses and the field outputs are unchanged; the next state is IDLE in both cases.
REQ-028 Latency: arp_valid/arp_error is high exactly 2 cycles after the accepting edge of the tlast beat.
REQ-029 Field outputs hold their value between good frames; capture registers never drive outputs directly.
REQ-030 arp_valid and arp_error are never high in the same cycle.
REQ-031 A tuser beat arriving in the CHECK cycle is accepted and starts a new frame (IDLE rules); the CHECK result is still emitted.
REQ-032 The byte counter is 5 bits and saturates at 27; the pad counter is 8 bits with no wrap.

Reset
REQ-033 Reset is asynchronous assertion with synchronous-safe deassertion; state=IDLE, counters=0, arp_valid=0, arp_error=0, all field outputs=0, s_axis_tready=0 while s_axis_aresetn=0.
REQ-034 Reset mid-frame discards the partial frame with no pulse.

Verification
REQ-035 28-byte request, opcode 1, srcMac 00:0a:35:01:02:03, srcIP 192.168.1.10, destIP=local_ip=192.168.1.2 -> arp_valid one cycle, 2 cycles after tlast; fields match; arp_error=0.
REQ-036 Same frame with 18 pad bytes (46-byte payload) and random tvalid gaps -> single arp_valid, identical fields.
REQ-037 destIP 192.168.1.99, CHECK_IP=1 -> arp_error pulse, fields hold previous values; with CHECK_IP=0 -> arp_valid.
REQ-038 tlast on byte 20 -> arp_error 1 cycle after that beat; next good frame is then received normally.
REQ-039 tuser reasserted at byte 10, followed by a full good frame -> one arp_error, then one arp_valid for the second frame.
REQ-040 s_axis_aresetn pulsed low at byte 15 -> all outputs 0, no pulses; the following good frame yields arp_valid.

Source files
------------

// File: rtl/rx_arp.sv
// rx_arp: byte-serial ARP payload receiver. Captures the 28-byte ARP header,
// skips trailing Ethernet pad, validates the packet and presents its fields.
module rx_arp #(
   parameter int         CHECK_IP = 1,
   parameter logic [7:0] MAX_PAD  = 8'd64
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_aresetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tuser,
   input  logic        s_axis_tlast,
   input  logic [31:0] local_ip,
   output logic [15:0] arp_opcode,
   output logic [47:0] arp_srcMac,
   output logic [31:0] arp_srcIP,
   output logic [47:0] arp_destMac,
   output logic [31:0] arp_destIP,
   output logic        arp_valid,
   output logic        arp_error
);

   typedef enum logic [1:0] {IDLE, HEADER, PAD, CHECK} state_t;

   state_t      state, state_nxt;
   logic [4:0]  byte_cnt, byte_cnt_nxt;
   logic [7:0]  pad_cnt, pad_cnt_nxt;
   logic        accept;
   logic        restart;
   logic        store_en;
   logic [4:0]  store_idx;
   logic        vld_p0, err_p0;
   logic        frame_good;
   logic [7:0]  cap [28];

   logic [15:0] cap_hw_type, cap_proto, cap_opcode;
   logic [47:0] cap_src_mac, cap_dest_mac;
   logic [31:0] cap_src_ip, cap_dest_ip;

   assign accept = s_axis_tvalid & s_axis_tready;

   assign cap_hw_type  = {cap[0], cap[1]};
   assign cap_proto    = {cap[2], cap[3]};
   assign cap_opcode   = {cap[6], cap[7]};
   assign cap_src_mac  = {cap[8], cap[9], cap[10], cap[11], cap[12], cap[13]};
   assign cap_src_ip   = {cap[14], cap[15], cap[16], cap[17]};
   assign cap_dest_mac = {cap[18], cap[19], cap[20], cap[21], cap[22], cap[23]};
   assign cap_dest_ip  = {cap[24], cap[25], cap[26], cap[27]};

   assign frame_good = (cap_hw_type == 16'h0001) && (cap_proto == 16'h0800) &&
                       (cap[4] == 8'd6) && (cap[5] == 8'd4) &&
                       ((cap_opcode == 16'd1) || (cap_opcode == 16'd2)) &&
                       ((CHECK_IP == 0) || (cap_dest_ip == local_ip));

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         state    <= IDLE;
         byte_cnt <= 5'd0;
         pad_cnt  <= 8'd0;
      end else begin
         state    <= state_nxt;
         byte_cnt <= byte_cnt_nxt;
         pad_cnt  <= pad_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      pad_cnt_nxt  = pad_cnt;
      store_en     = 1'b0;
      store_idx    = byte_cnt;
      vld_p0       = 1'b0;
      err_p0       = 1'b0;
      restart      = 1'b0;
      case (state)
         IDLE: begin
            restart = accept & s_axis_tuser;
         end
         HEADER: begin
            if (accept) begin
               if (s_axis_tuser) begin
                  err_p0  = 1'b1;
                  restart = 1'b1;
               end else begin
                  store_en = 1'b1;
                  if (byte_cnt == 5'd27) begin
                     if (s_axis_tlast) begin
                        state_nxt = CHECK;
                     end else begin
                        state_nxt   = PAD;
                        pad_cnt_nxt = 8'd0;
                     end
                  end else if (s_axis_tlast) begin
                     err_p0       = 1'b1;
                     state_nxt    = IDLE;
                     byte_cnt_nxt = 5'd0;
                  end else begin
                     byte_cnt_nxt = byte_cnt + 5'd1;
                  end
               end
            end
         end
         PAD: begin
            if (accept) begin
               if (s_axis_tuser) begin
                  err_p0  = 1'b1;
                  restart = 1'b1;
               end else if (s_axis_tlast) begin
                  state_nxt = CHECK;
               end else begin
                  pad_cnt_nxt = (pad_cnt == 8'hFF) ? pad_cnt : pad_cnt + 8'd1;
                  if (pad_cnt_nxt >= MAX_PAD) begin
                     err_p0       = 1'b1;
                     state_nxt    = IDLE;
                     byte_cnt_nxt = 5'd0;
                     pad_cnt_nxt  = 8'd0;
                  end
               end
            end
         end
         CHECK: begin
            vld_p0       = frame_good;
            err_p0       = ~frame_good;
            state_nxt    = IDLE;
            byte_cnt_nxt = 5'd0;
            pad_cnt_nxt  = 8'd0;
            // a new frame may start while this one is being judged
            restart      = accept & s_axis_tuser;
         end
         default: state_nxt = IDLE;
      endcase
      if (restart) begin
         store_en     = 1'b1;
         store_idx    = 5'd0;
         byte_cnt_nxt = 5'd1;
         state_nxt    = HEADER;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      for (int i = 0; i < 28; i++) begin
         if (store_en && (store_idx == 5'(i))) cap[i] <= s_axis_tdata;
      end
   end

   // ---- output stage: judged frame fields and result pulses ----
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         s_axis_tready <= 1'b0;
         arp_valid     <= 1'b0;
         arp_error     <= 1'b0;
         arp_opcode    <= 16'd0;
         arp_srcMac    <= 48'd0;
         arp_srcIP     <= 32'd0;
         arp_destMac   <= 48'd0;
         arp_destIP    <= 32'd0;
      end else begin
         s_axis_tready <= 1'b1;
         arp_valid     <= vld_p0;
         arp_error     <= err_p0;
         if (vld_p0) begin
            arp_opcode  <= cap_opcode;
            arp_srcMac  <= cap_src_mac;
            arp_srcIP   <= cap_src_ip;
            arp_destMac <= cap_dest_mac;
            arp_destIP  <= cap_dest_ip;
         end
      end
   end

endmodule

// File: tb/tb_rx_arp.sv
// Scoreboard bench for rx_arp: a frame-level stream model predicts each
// result pulse (kind, cycle, fields) for a CHECK_IP=1 and a CHECK_IP=0 instance.
module tb_rx_arp;

   localparam int          MAX_PAD  = 64;
   localparam logic [31:0] LOCAL_IP = 32'hC0A80102;
   localparam logic [47:0] SM       = 48'h000A35010203;
   localparam logic [31:0] SI       = 32'hC0A8010A;

   typedef struct { logic [7:0] d; bit user; bit last; } beat_t;
   typedef struct { int beat; int lat; bit vld; logic [175:0] f; } mev_t;
   typedef struct { int cyc; bit vld; logic [175:0] f; } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  tdata = 8'd0;
   logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
   logic        tready0, tready1, v0, v1, e0, e1;
   logic [15:0] op0, op1;
   logic [47:0] sm0, sm1, dm0, dm1;
   logic [31:0] si0, si1, di0, di1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit gaps = 1'b0;

   beat_t        stream[$];
   mev_t         ev0[$], ev1[$];
   exp_t         sb0[$], sb1[$];
   logic [175:0] held [2];
   logic [7:0]   h [28];

   rx_arp #(.CHECK_IP(1), .MAX_PAD(8'd64)) u0 (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(tdata),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready0), .s_axis_tuser(tuser),
      .s_axis_tlast(tlast), .local_ip(LOCAL_IP), .arp_opcode(op0),
      .arp_srcMac(sm0), .arp_srcIP(si0), .arp_destMac(dm0), .arp_destIP(di0),
      .arp_valid(v0), .arp_error(e0));

   rx_arp #(.CHECK_IP(0), .MAX_PAD(8'd64)) u1 (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(tdata),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready1), .s_axis_tuser(tuser),
      .s_axis_tlast(tlast), .local_ip(LOCAL_IP), .arp_opcode(op1),
      .arp_srcMac(sm1), .arp_srcIP(si1), .arp_destMac(dm1), .arp_destIP(di1),
      .arp_valid(v1), .arp_error(e1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic mon(input int inst, input logic v, input logic e, input logic [175:0] f);
      exp_t x;
      if (v || e) begin
         checks++;
         if (v && e) begin
            errors++;
            $display("FAIL exclusive inst%0d: valid and error both high at cyc %0d", inst, cyc);
         end
         if ((inst == 0 && sb0.size() == 0) || (inst == 1 && sb1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse inst%0d: valid=%0b error=%0b at cyc %0d, none expected", inst, v, e, cyc);
         end else begin
            if (inst == 0) x = sb0.pop_front();
            else x = sb1.pop_front();
            checks++;
            if (v !== x.vld || cyc != x.cyc) begin
               errors++;
               $display("FAIL pulse inst%0d: got valid=%0b error=%0b at cyc %0d, expected %s at cyc %0d",
                        inst, v, e, cyc, x.vld ? "valid" : "error", x.cyc);
            end
            checks++;
            if (f !== x.f) begin
               errors++;
               $display("FAIL fields inst%0d: got %h expected %h", inst, f, x.f);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, v0, e0, {op0, sm0, si0, dm0, di0});
      mon(1, v1, e1, {op1, sm1, si1, dm1, di1});
   end

   task automatic set_hdr(input logic [15:0] hw, input logic [15:0] pr, input logic [7:0] hl,
                          input logic [7:0] pl, input logic [15:0] op, input logic [47:0] sm,
                          input logic [31:0] si, input logic [47:0] dm, input logic [31:0] di);
      logic [223:0] hv;
      hv = {hw, pr, hl, pl, op, sm, si, dm, di};
      for (int i = 0; i < 28; i++) h[i] = hv[223 - 8*i -: 8];
   endtask

   task automatic push_bytes(input int n_hdr, input int n_pad, input bit with_last);
      beat_t bt;
      for (int i = 0; i < n_hdr + n_pad; i++) begin
         bt.d    = (i < n_hdr) ? h[i] : 8'($urandom);
         bt.user = (i == 0);
         bt.last = with_last && (i == n_hdr + n_pad - 1);
         stream.push_back(bt);
      end
   endtask

   task automatic push_junk(input int n);
      beat_t bt;
      for (int i = 0; i < n; i++) begin
         bt.d = 8'($urandom); bt.user = 1'b0; bt.last = 1'($urandom_range(0, 1));
         stream.push_back(bt);
      end
   endtask

   task automatic add_ev(input int inst, input int beat, input int lat, input bit vld,
                         input logic [175:0] f);
      mev_t m;
      m.beat = beat; m.lat = lat; m.vld = vld; m.f = f;
      if (inst == 0) ev0.push_back(m);
      else ev1.push_back(m);
   endtask

   // Frame-level reference: split the beat stream into frames and decide each outcome.
   task automatic model(input int inst, input bit chk);
      int pos, start, j, k;
      bit done, good;
      logic [7:0] b [28];
      logic [175:0] f;
      pos = 0;
      while (pos < stream.size()) begin
         if (!stream[pos].user) pos++;
         else begin
            start = pos; j = pos + 1; done = 1'b0;
            while (!done) begin
               if (j >= stream.size()) begin
                  pos = j; done = 1'b1;
               end else if (stream[j].user) begin
                  add_ev(inst, j, 1, 1'b0, held[inst]);
                  pos = j; done = 1'b1;
               end else begin
                  k = j - start;
                  if (stream[j].last && k < 27) begin
                     add_ev(inst, j, 1, 1'b0, held[inst]);
                     pos = j + 1; done = 1'b1;
                  end else if (stream[j].last) begin
                     for (int m = 0; m < 28; m++) b[m] = stream[start + m].d;
                     f = '0;
                     for (int m = 6; m < 28; m++) f = {f[167:0], b[m]};
                     good = ({b[0], b[1]} == 16'h0001) && ({b[2], b[3]} == 16'h0800) &&
                            (b[4] == 8'd6) && (b[5] == 8'd4) &&
                            ({b[6], b[7]} == 16'd1 || {b[6], b[7]} == 16'd2) &&
                            (!chk || {b[24], b[25], b[26], b[27]} == LOCAL_IP);
                     if (good) held[inst] = f;
                     add_ev(inst, j, 2, good, held[inst]);
                     pos = j + 1; done = 1'b1;
                  end else if (k > 27 && k - 27 >= MAX_PAD) begin
                     add_ev(inst, j, 1, 1'b0, held[inst]);
                     pos = j + 1; done = 1'b1;
                  end else begin
                     j++;
                  end
               end
            end
         end
      end
   endtask

   task automatic release_events(input int beat, input int b);
      exp_t x;
      while (ev0.size() > 0 && ev0[0].beat == beat) begin
         x.cyc = b + ev0[0].lat; x.vld = ev0[0].vld; x.f = ev0[0].f;
         sb0.push_back(x); void'(ev0.pop_front());
      end
      while (ev1.size() > 0 && ev1[0].beat == beat) begin
         x.cyc = b + ev1[0].lat; x.vld = ev1[0].vld; x.f = ev1[0].f;
         sb1.push_back(x); void'(ev1.pop_front());
      end
   endtask

   task automatic drive_stream();
      bit acc;
      int tries;
      for (int i = 0; i < stream.size(); i++) begin
         acc = 1'b0; tries = 0;
         while (!acc && tries < 200) begin
            @(negedge clk);
            tries++;
            if (gaps && $urandom_range(0, 2) == 0) begin
               tvalid = 1'b0; tdata = 8'($urandom);
               tuser = 1'($urandom_range(0, 1)); tlast = 1'($urandom_range(0, 1));
            end else begin
               tvalid = 1'b1; tdata = stream[i].d; tuser = stream[i].user; tlast = stream[i].last;
               if (tready0) begin
                  acc = 1'b1;
                  release_events(i, cyc);
               end
            end
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL beat_timeout: beat %0d not accepted, tready=%0b required 1", i, tready0);
         end
      end
      @(negedge clk);
      tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
   endtask

   task automatic run_stream(input string name);
      ev0.delete(); ev1.delete();
      model(0, 1'b1);
      model(1, 1'b0);
      drive_stream();
      repeat (6) @(negedge clk);
      checks++;
      if (sb0.size() != 0 || ev0.size() != 0) begin
         errors++;
         $display("FAIL %s_pending inst0: %0d pulses missing, required 0", name, sb0.size() + ev0.size());
      end
      checks++;
      if (sb1.size() != 0 || ev1.size() != 0) begin
         errors++;
         $display("FAIL %s_pending inst1: %0d pulses missing, required 0", name, sb1.size() + ev1.size());
      end
      sb0.delete(); sb1.delete();
      stream.delete();
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (tready0 !== 1'b0 || tready1 !== 1'b0) begin
         errors++;
         $display("FAIL %s_tready: got %0b/%0b required 0/0", name, tready0, tready1);
      end
      checks++;
      if ({v0, e0, v1, e1} !== 4'b0) begin
         errors++;
         $display("FAIL %s_pulses: got %b required 0000", name, {v0, e0, v1, e1});
      end
      checks++;
      if ({op0, sm0, si0, dm0, di0} !== 176'd0) begin
         errors++;
         $display("FAIL %s_fields0: got %h required 0", name, {op0, sm0, si0, dm0, di0});
      end
      checks++;
      if ({op1, sm1, si1, dm1, di1} !== 176'd0) begin
         errors++;
         $display("FAIL %s_fields1: got %h required 0", name, {op1, sm1, si1, dm1, di1});
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] op, hw;
      logic [31:0] di;
      held[0] = '0; held[1] = '0;
      #2 rst_n = 1'b0;
      #1 check_reset("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // basic request, then a reply starting in the judging cycle
      gaps = 1'b0;
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, SM, SI, 48'd0, LOCAL_IP);
      push_bytes(28, 0, 1'b1);
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2, SM + 48'd1, SI + 32'd1, 48'h112233445566, LOCAL_IP);
      push_bytes(28, 0, 1'b1);
      run_stream("basic");

      gaps = 1'b1;
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, SM, SI, 48'd0, LOCAL_IP);
      push_bytes(28, 18, 1'b1);
      run_stream("pad18");

      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, SM, SI, 48'd0, 32'hC0A80163);
      push_bytes(28, 0, 1'b1);
      run_stream("foreign_ip");

      gaps = 1'b0;
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, SM, SI, 48'd0, LOCAL_IP);
      push_bytes(21, 0, 1'b1);
      push_bytes(28, 0, 1'b1);
      run_stream("short");

      push_bytes(10, 0, 1'b0);
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd2, SM + 48'd7, SI, 48'hA0A1A2A3A4A5, LOCAL_IP);
      push_bytes(28, 0, 1'b1);
      run_stream("restart");

      gaps = 1'b1;
      push_bytes(28, 70, 1'b1);
      push_bytes(28, 0, 1'b1);
      run_stream("pad_overflow");

      for (int n = 0; n < 14; n++) begin
         op = 16'($urandom_range(1, 3));
         hw = ($urandom_range(0, 5) == 0) ? 16'h0002 : 16'h0001;
         di = ($urandom_range(0, 2) == 0) ? 32'($urandom) : LOCAL_IP;
         set_hdr(hw, 16'h0800, 8'd6, 8'd4, op, {16'($urandom), 32'($urandom)}, 32'($urandom),
                 {16'($urandom), 32'($urandom)}, di);
         push_bytes(28, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0, 1'b1);
         if ($urandom_range(0, 3) == 0) push_junk(int'($urandom_range(1, 3)));
      end
      run_stream("random");

      // reset in the middle of a header
      gaps = 1'b0;
      set_hdr(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd1, SM, SI, 48'd0, LOCAL_IP);
      push_bytes(15, 0, 1'b0);
      run_stream("partial");
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset("midframe");
      held[0] = '0; held[1] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_bytes(28, 0, 1'b1);
      run_stream("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
